// File: rtl/control_unit_pipe.sv
// LEGv8 main control decoder feeding a 2-entry ready/valid buffer between IF/ID and ID/EX.
// Illegal opcodes decode to all-zero controls with a sticky, saturating illegal counter.
module control_unit_pipe #(
    parameter int OPCODE_W  = 11,
    parameter int ALUOP_W   = 2,
    parameter int ILL_CNT_W = 8,
    parameter bit EN_IMM    = 1'b1
) (
    input  logic                 CLOCK,
    input  logic                 RESET_N,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 flush,
    output logic                 ctrl_valid,
    input  logic                 ctrl_ready,
    output logic                 reg2Loc,
    output logic                 ALUsrc,
    output logic                 memtoReg,
    output logic                 regWrite,
    output logic                 memRead,
    output logic                 memWrite,
    output logic                 branch,
    output logic                 branch_nz,
    output logic                 uncondBranch,
    output logic [ALUOP_W-1:0]   ALUop,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] illegal_count
);

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_BR   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(2);

    typedef struct packed {
        logic               reg2loc;
        logic               alusrc;
        logic               memtoreg;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               branch;
        logic               branch_nz;
        logic               uncond;
        logic [ALUOP_W-1:0] aluop;
        logic               illegal;
    } ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    ctrl_t                 head_q, head_d, tail_q, tail_d;
    ctrl_t                 dec;
    logic [ILL_CNT_W-1:0]  ill_cnt_q, ill_cnt_d;
    logic                  push, pop;
    logic [10:0]           op;

    assign op   = opcode[OPCODE_W-1 -: 11];
    assign push = instr_valid & instr_ready & ~flush;
    assign pop  = ctrl_valid & ctrl_ready;

    // casez item order encodes the decode priority: B, CBZ/CBNZ, immediates, exact matches
    always_comb begin
        dec = '0;
        casez (op)
            11'b000101?????: begin
                dec.uncond = 1'b1;
                dec.aluop  = ALU_BR;
            end
            11'b1011010????: begin
                dec.reg2loc   = 1'b1;
                dec.branch    = 1'b1;
                dec.branch_nz = op[3];
                dec.aluop     = ALU_BR;
            end
            11'b1001000100?,
            11'b1101000100?: begin
                if (EN_IMM) begin
                    dec.alusrc   = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.aluop    = ALU_FUNC;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            11'b11111000010: begin
                dec.reg2loc  = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.aluop    = ALU_ADD;
            end
            11'b11111000000: begin
                dec.reg2loc  = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                dec.aluop    = ALU_ADD;
            end
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: begin
                dec.regwrite = 1'b1;
                dec.aluop    = ALU_FUNC;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (push) state_d = ONE;
                ONE: begin
                    if (push && !pop)      state_d = FULL;
                    else if (pop && !push) state_d = EMPTY;
                end
                FULL:    if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        ctrl_valid   = (state_q != EMPTY);
        instr_ready  = (state_q != FULL);
        reg2Loc      = 1'b0;
        ALUsrc       = 1'b0;
        memtoReg     = 1'b0;
        regWrite     = 1'b0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        branch       = 1'b0;
        branch_nz    = 1'b0;
        uncondBranch = 1'b0;
        ALUop        = '0;
        illegal      = 1'b0;
        if (state_q != EMPTY) begin
            reg2Loc      = head_q.reg2loc;
            ALUsrc       = head_q.alusrc;
            memtoReg     = head_q.memtoreg;
            regWrite     = head_q.regwrite;
            memRead      = head_q.memread;
            memWrite     = head_q.memwrite;
            branch       = head_q.branch;
            branch_nz    = head_q.branch_nz;
            uncondBranch = head_q.uncond;
            ALUop        = head_q.aluop;
            illegal      = head_q.illegal;
        end
        illegal_count = ill_cnt_q;
    end

    // Slot contents are only meaningful below the count; stale slots are never observed.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        ill_cnt_d = ill_cnt_q;
        if (!flush) begin
            if (pop) head_d = tail_q;
            if (push) begin
                if (state_q == EMPTY || (state_q == ONE && pop)) head_d = dec;
                else                                             tail_d = dec;
            end
        end
        if (push && dec.illegal && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
            ill_cnt_d = ill_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            head_q    <= '0;
            tail_q    <= '0;
            ill_cnt_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

endmodule
